// File: rtl/instr_decode_pkg.sv
// Shared constants and the decoded-entry type for the instruction decode stage.
// Default field layout, high to low: op | rs | rt | rd | imm.
package instr_decode_pkg;

  localparam int INSTR_W_DEF = 24;
  localparam int OP_W_DEF    = 6;
  localparam int REG_W_DEF   = 2;
  localparam int DATA_W_DEF  = 16;
  localparam int NUM_OPS_DEF = 32;
  localparam int IMM_W_DEF   = INSTR_W_DEF - OP_W_DEF - 3 * REG_W_DEF;

  // Least-significant bit position of each field in the raw instruction.
  localparam int OP_LSB  = INSTR_W_DEF - OP_W_DEF;
  localparam int RS_LSB  = OP_LSB - REG_W_DEF;
  localparam int RT_LSB  = RS_LSB - REG_W_DEF;
  localparam int RD_LSB  = RT_LSB - REG_W_DEF;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [REG_W_DEF-1:0]  rs;
    logic [REG_W_DEF-1:0]  rt;
    logic [REG_W_DEF-1:0]  rd;
    logic [DATA_W_DEF-1:0] imm;
    logic                  illegal;
  } decoded_t;

endpackage

// File: rtl/instr_decode_if.sv
// Upstream and downstream handshake bundle of the instruction decode stage.
// slave = the decode stage, master = the surrounding environment.
interface instr_decode_if #(
  parameter int INSTR_W = 24,
  parameter int OP_W    = 6,
  parameter int REG_W   = 2,
  parameter int DATA_W  = 16
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               in_imm_signed;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    out_op;
  logic [REG_W-1:0]   out_rs;
  logic [REG_W-1:0]   out_rt;
  logic [REG_W-1:0]   out_rd;
  logic [DATA_W-1:0]  out_imm;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_instr, in_imm_signed, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_imm_signed, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_imm, out_illegal
  );

endinterface

// File: rtl/instr_skid_buf.sv
// Two-entry elastic buffer (output register + one skid register) with a
// registered in_ready, so upstream never sees a combinational path from out_ready.
module instr_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_r, skid_full_r, in_ready_r;
  logic [W-1:0] out_data_r, skid_data_r;
  logic         out_valid_s, skid_full_s;
  logic [W-1:0] out_data_s, skid_data_s;
  logic         in_xfer_s, out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next-state of both entries; flush discards everything, including a same-cycle input.
  always_comb begin
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    skid_full_s = skid_full_r;
    skid_data_s = skid_data_r;
    if (flush) begin
      out_valid_s = 1'b0;
      skid_full_s = 1'b0;
    end else if (!out_valid_r || out_xfer_s) begin
      if (skid_full_r) begin
        out_valid_s = 1'b1;
        out_data_s  = skid_data_r;
        skid_full_s = 1'b0;
      end else if (in_xfer_s) begin
        out_valid_s = 1'b1;
        out_data_s  = in_data;
      end else begin
        out_valid_s = 1'b0;
      end
    end else if (in_xfer_s) begin
      skid_full_s = 1'b1;
      skid_data_s = in_data;
    end else begin
      skid_full_s = skid_full_r;
    end
  end

  // Entry registers; in_ready is held low through reset and follows the skid state after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      skid_full_r <= 1'b0;
      skid_data_r <= '0;
      in_ready_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      skid_full_r <= skid_full_s;
      skid_data_r <= skid_data_s;
      in_ready_r  <= ~skid_full_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: slices op/rs/rt/rd/imm, extends the immediate and buffers
// the result in a two-entry skid buffer. Define INSTR_DECODE_ILLEGAL_EN to flag op >= NUM_OPS.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  instr_decode_if.slave  bus
);

  localparam int IMM_W = INSTR_W - OP_W - 3 * REG_W;
  localparam int PAY_W = OP_W + 3 * REG_W + DATA_W + 1;

  generate
    if (IMM_W < 1 || IMM_W > DATA_W) begin : g_bad_imm_w
      $error("instr_decode_stage: IMM_W out of range 1..DATA_W");
    end
  endgenerate

  logic [OP_W-1:0]   op_s;
  logic [REG_W-1:0]  rs_s, rt_s, rd_s;
  logic [IMM_W-1:0]  imm_raw_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic              illegal_s;
  logic [PAY_W-1:0]  in_pay_s, out_pay_s;

  assign op_s      = bus.in_instr[INSTR_W-1 -: OP_W];
  assign rs_s      = bus.in_instr[INSTR_W-OP_W-1 -: REG_W];
  assign rt_s      = bus.in_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
  assign rd_s      = bus.in_instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
  assign imm_raw_s = bus.in_instr[IMM_W-1:0];

  // Immediate extension, chosen per instruction.
  always_comb begin
    imm_ext_s = '0;
    if (bus.in_imm_signed) begin
      imm_ext_s = DATA_W'($signed(imm_raw_s));
    end else begin
      imm_ext_s = DATA_W'(imm_raw_s);
    end
  end

`ifdef INSTR_DECODE_ILLEGAL_EN
  assign illegal_s = (32'(op_s) >= 32'(NUM_OPS));
`else
  assign illegal_s = 1'b0;
`endif

  assign in_pay_s = {op_s, rs_s, rt_s, rd_s, imm_ext_s, illegal_s};

  instr_skid_buf #(.W(PAY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_pay_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_pay_s)
  );

  assign {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_imm, bus.out_illegal} = out_pay_s;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (default parameters).
module tb_instr_decode_stage;
  import instr_decode_pkg::*;

`ifdef INSTR_DECODE_ILLEGAL_EN
  localparam bit ILL_ON = 1'b1;
`else
  localparam bit ILL_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic flush;
  int   n_cmp;
  int   n_err;

  instr_decode_if #(.INSTR_W(24), .OP_W(6), .REG_W(2), .DATA_W(16)) bus ();

  instr_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded vectors: {op, rs, rt, rd, imm, illegal}
  localparam logic [23:0] I_A = 24'hA53123;   // op 29, rs 1, rt 0, rd 3, imm 123
  localparam logic [23:0] I_B = 24'h0C5A5A;   // op 03, rs 0, rt 1, rd 1, imm A5A
  localparam logic [23:0] I_C = 24'hFF8001;   // op 3F, rs 3, rt 2, rd 0, imm 001
  localparam logic [23:0] I_D = 24'h7E4800;   // op 1F, rs 2, rt 1, rd 0, imm 800
  localparam logic [23:0] I_E = 24'h000FFF;

  function automatic logic [28:0] observed();
    return {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_imm, bus.out_illegal};
  endfunction

  task automatic drive(input logic v, input logic [23:0] ins, input logic sgn);
    bus.in_valid      = v;
    bus.in_instr      = ins;
    bus.in_imm_signed = sgn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 24'h000000, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, observed()} !== 31'd0) begin
      n_err++; $display("FAIL reset_state: got %h expected 0", {bus.out_valid, bus.in_ready, observed()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_release: got rdy/vld %b expected 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_decode_fields();
    bus.out_ready = 1'b1;
    drive(1'b1, I_A, 1'b0);
    @(negedge clk);
    drive(1'b0, 24'h000000, 1'b0);
    n_cmp++;
    if ({bus.out_valid, observed()} !== {1'b1, 6'h29, 2'd1, 2'd0, 2'd3, 16'h0123, ILL_ON}) begin
      n_err++; $display("FAIL decode_a53123: got %h expected %h", {bus.out_valid, observed()},
                        {1'b1, 6'h29, 2'd1, 2'd0, 2'd3, 16'h0123, ILL_ON});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL decode_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_imm_ext();
    bus.out_ready = 1'b1;
    drive(1'b1, I_E, 1'b1);
    @(negedge clk);
    drive(1'b1, I_E, 1'b0);
    n_cmp++;
    if (bus.out_imm !== 16'hFFFF) begin
      n_err++; $display("FAIL imm_sext_fff: got %h expected FFFF", bus.out_imm);
    end
    @(negedge clk);
    drive(1'b1, I_D, 1'b1);
    n_cmp++;
    if (bus.out_imm !== 16'h0FFF) begin
      n_err++; $display("FAIL imm_zext_fff: got %h expected 0FFF", bus.out_imm);
    end
    @(negedge clk);
    drive(1'b0, 24'h000000, 1'b0);
    n_cmp++;
    if (observed() !== {6'h1F, 2'd2, 2'd1, 2'd0, 16'hF800, 1'b0}) begin
      n_err++; $display("FAIL imm_sext_800: got %h expected %h", observed(), {6'h1F, 2'd2, 2'd1, 2'd0, 16'hF800, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_skid();
    bus.out_ready = 1'b0;
    drive(1'b1, I_B, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL skid_one_entry_ready: got %b expected 1", bus.in_ready);
    end
    drive(1'b1, I_C, 1'b1);
    @(negedge clk);
    drive(1'b0, 24'h000000, 1'b0);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL skid_full_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, observed()} !== {1'b1, 6'h03, 2'd0, 2'd1, 2'd1, 16'h0A5A, 1'b0}) begin
      n_err++; $display("FAIL skid_hold_first: got %h expected %h", {bus.out_valid, observed()},
                        {1'b1, 6'h03, 2'd0, 2'd1, 2'd1, 16'h0A5A, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, observed()} !== {2'b11, 6'h3F, 2'd3, 2'd2, 2'd0, 16'h0001, ILL_ON}) begin
      n_err++; $display("FAIL skid_second_out: got %h expected %h", {bus.out_valid, bus.in_ready, observed()},
                        {2'b11, 6'h3F, 2'd3, 2'd2, 2'd0, 16'h0001, ILL_ON});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++; $display("FAIL skid_drained: got vld/rdy %b expected 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ins [4];
    logic        sg  [4];
    logic [28:0] ex  [4];
    ins[0] = I_A; sg[0] = 1'b0; ex[0] = {6'h29, 2'd1, 2'd0, 2'd3, 16'h0123, ILL_ON};
    ins[1] = I_B; sg[1] = 1'b0; ex[1] = {6'h03, 2'd0, 2'd1, 2'd1, 16'h0A5A, 1'b0};
    ins[2] = I_C; sg[2] = 1'b1; ex[2] = {6'h3F, 2'd3, 2'd2, 2'd0, 16'h0001, ILL_ON};
    ins[3] = I_D; sg[3] = 1'b1; ex[3] = {6'h1F, 2'd2, 2'd1, 2'd0, 16'hF800, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], sg[i]);
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {2'b11, ex[i]}) begin
        n_err++; $display("FAIL b2b_%0d: got %h expected %h", i, {bus.out_valid, bus.in_ready, observed()}, {2'b11, ex[i]});
      end
    end
    drive(1'b0, 24'h000000, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    // Both entries full plus a pending input, then flush.
    bus.out_ready = 1'b0;
    drive(1'b1, I_A, 1'b0); @(negedge clk);
    drive(1'b1, I_B, 1'b0); @(negedge clk);
    drive(1'b1, I_C, 1'b1); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; drive(1'b0, 24'h000000, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_full: got vld/rdy %b expected 01", {bus.out_valid, bus.in_ready});
    end
    // One entry full while an input transfer coincides with flush.
    drive(1'b1, I_D, 1'b1); @(negedge clk);
    drive(1'b1, I_E, 1'b0); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; drive(1'b0, 24'h000000, 1'b0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL flush_dropped: got %0d outputs expected 0", seen);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, I_A, 1'b0); @(negedge clk);
    drive(1'b1, I_D, 1'b0);
    n_cmp++;
    if (bus.out_illegal !== ILL_ON) begin
      n_err++; $display("FAIL illegal_op29: got %b expected %b", bus.out_illegal, ILL_ON);
    end
    @(negedge clk);
    drive(1'b0, 24'h000000, 1'b0);
    n_cmp++;
    if ({bus.out_valid, bus.out_op, bus.out_illegal} !== {1'b1, 6'h1F, 1'b0}) begin
      n_err++; $display("FAIL illegal_op1f: got %h expected %h", {bus.out_valid, bus.out_op, bus.out_illegal}, {1'b1, 6'h1F, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_random_reset();
    logic [28:0] q [$];
    logic [28:0] ex;
    logic [23:0] r;
    logic        s;
    int          ord_err;
    ord_err = 0;
    for (int c = 0; c < 60; c++) begin
      r = 24'($urandom);
      s = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), r, s);
      bus.out_ready = (c < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({r[23:12], {4{s & r[11]}}, r[11:0], ILL_ON & (r[23:18] >= 6'd32)});
      end
      if (bus.out_valid && bus.out_ready) begin
        ex = (q.size() > 0) ? q.pop_front() : 29'h1FFFFFFF;
        n_cmp++;
        if (observed() !== ex) begin
          n_err++; ord_err++;
          if (ord_err < 5) $display("FAIL rand_order_%0d: got %h expected %h", c, observed(), ex);
        end
      end
      @(negedge clk);
    end
    drive(1'b1, I_A, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, observed()} !== 31'd0) begin
      n_err++; $display("FAIL async_reset_clear: got %h expected 0", {bus.out_valid, bus.in_ready, observed()});
    end
    drive(1'b0, 24'h000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_rerelease: got rdy/vld %b expected 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_decode_fields();
    test_imm_ext();
    test_skid();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
